// File: rtl/hfu_pkg.sv
// hfu_pkg: shared forwarding encodings, stage-entry type and match helper for hazard_fwd_unit
package hfu_pkg;
  localparam int HFU_NREG = 32;
  localparam int HFU_NSRC = 2;
  localparam int HFU_AW = $clog2(HFU_NREG);
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic [HFU_AW-1:0] dst;
    logic load;
    logic mul;
    logic [HFU_NSRC-1:0][HFU_AW-1:0] src;
    logic [HFU_NSRC-1:0] used;
  } entry_t;
  function automatic logic writes(input entry_t e, input logic [HFU_AW-1:0] r);
    return e.valid && e.regwrite && e.dst == r && r != '0;
  endfunction
endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match: forwarding select for one EX operand from the MEM and WB entries
module fwd_src_match
  import hfu_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_used,
  input  logic [HFU_AW-1:0] ex_src,
  input  entry_t            mem,
  input  entry_t            wb,
  output logic [1:0]        sel
);
  assign sel = !(ex_valid && ex_used) ? FWD_RF :
               (writes(mem, ex_src) && !mem.load) ? FWD_MEM :
               writes(wb, ex_src) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX forwarding, ID write-back bypass, load-use stall and multiply hold
module hazard_fwd_unit
  import hfu_pkg::*;
#(
  parameter int NREG = HFU_NREG,
  parameter int NSRC = HFU_NSRC,
  parameter int MUL_LAT = 3,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [NSRC*AW-1:0] id_src_addr_i,
  input  logic [NSRC-1:0]   id_src_used_i,
  input  logic [AW-1:0]     id_dst_addr_i,
  input  logic              id_regwrite_i,
  input  logic              id_load_i,
  input  logic              id_mul_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [NSRC*2-1:0] ex_fwd_sel_o,
  output logic [NSRC-1:0]   id_wb_bypass_o
);
  localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  entry_t ex, mem, wb, id_e;
  logic [CW-1:0] cnt;
  logic [NSRC-1:0] lu_hit;
  logic load_use, mul_busy;
  assign id_e = {id_valid_i & ~flush_i, id_regwrite_i, id_dst_addr_i, id_load_i, id_mul_i,
                 id_src_addr_i, id_src_used_i};
  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [AW-1:0] a;
    assign a = id_src_addr_i[k*AW +: AW];
    assign lu_hit[k] = id_src_used_i[k] && a == ex.dst;
    assign id_wb_bypass_o[k] = id_valid_i && id_src_used_i[k] && writes(wb, a);
    fwd_src_match u_match (
      .ex_valid(ex.valid),
      .ex_used (ex.used[k]),
      .ex_src  (ex.src[k]),
      .mem     (mem),
      .wb      (wb),
      .sel     (ex_fwd_sel_o[k*2 +: 2])
    );
  end
  assign load_use = ex.valid && ex.load && ex.regwrite && ex.dst != '0 && |lu_hit &&
                    id_valid_i && !flush_i;
  assign mul_busy = ex.mul && cnt != '0;
  assign stall_o = load_use || mul_busy;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      cnt <= '0;
    end else begin
      wb <= mem;
      mem <= mul_busy ? '0 : ex;
      ex <= mul_busy ? ex : load_use ? '0 : id_e;
      cnt <= (!stall_o && id_e.valid && id_e.mul) ? CW'(MUL_LAT - 1) :
             (cnt != '0) ? cnt - CW'(1) : cnt;
    end
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed vectors with a queued scoreboard checked by an independent monitor
module tb_hazard_fwd_unit;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic id_valid_i = 1'b0;
  logic [9:0] id_src_addr_i = '0;
  logic [1:0] id_src_used_i = '0;
  logic [4:0] id_dst_addr_i = '0;
  logic id_regwrite_i = 1'b0;
  logic id_load_i = 1'b0;
  logic id_mul_i = 1'b0;
  logic flush_i = 1'b0;
  logic stall_o;
  logic [3:0] ex_fwd_sel_o;
  logic [1:0] id_wb_bypass_o;
  typedef struct {
    logic stall;
    logic [3:0] sel;
    logic [1:0] byp;
    string name;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  hazard_fwd_unit #(.NREG(32), .NSRC(2), .MUL_LAT(3)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_src_addr_i (id_src_addr_i),
    .id_src_used_i (id_src_used_i),
    .id_dst_addr_i (id_dst_addr_i),
    .id_regwrite_i (id_regwrite_i),
    .id_load_i     (id_load_i),
    .id_mul_i      (id_mul_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .ex_fwd_sel_o  (ex_fwd_sel_o),
    .id_wb_bypass_o(id_wb_bypass_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input string f, input logic [3:0] got, input logic [3:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s.%s: got %b expected %b", n, f, got, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.name, "stall", {3'b0, stall_o}, {3'b0, e.stall});
      chk(e.name, "sel", ex_fwd_sel_o, e.sel);
      chk(e.name, "byp", {2'b0, id_wb_bypass_o}, {2'b0, e.byp});
    end
  end
  task automatic step(input string n, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] used, input logic [4:0] dst, input logic rw, input logic ld,
                      input logic ml, input logic fl, input logic es, input logic [3:0] esel,
                      input logic [1:0] eb, input logic r = 1'b1);
    @(posedge clk);
    #1;
    rst_i = r;
    id_valid_i = v;
    id_src_addr_i = {s1, s0};
    id_src_used_i = used;
    id_dst_addr_i = dst;
    id_regwrite_i = rw;
    id_load_i = ld;
    id_mul_i = ml;
    flush_i = fl;
    q.push_back('{es, esel, eb, n});
  endtask
  task automatic idle(input string n, input logic es = 1'b0, input logic [3:0] esel = 4'b0,
                      input logic r = 1'b1);
    step(n, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, es, esel, 2'b00, r);
  endtask
  task automatic drain();
    for (int i = 0; i < 3; i++) idle("drain");
  endtask
  initial begin
    repeat (2) @(posedge clk);
    idle("rst_state");
    step("a_add", 1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    step("a_sub", 1, 3, 4, 2'b11, 6, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    idle("a_fwd_mem", 0, 4'b0010);
    drain();
    step("b_add", 1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    idle("b_nop");
    step("b_c1", 1, 8, 3, 2'b11, 9, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    step("b_c2_bypass", 1, 3, 10, 2'b11, 11, 1, 0, 0, 0, 0, 4'b0100, 2'b01);
    idle("b_c2_ex");
    drain();
    step("c_lw", 1, 1, 0, 2'b01, 5, 1, 1, 0, 0, 0, 4'b0000, 2'b00);
    step("c_add_stall", 1, 2, 5, 2'b11, 6, 1, 0, 0, 0, 1, 4'b0000, 2'b00);
    step("c_add_held", 1, 2, 5, 2'b11, 6, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    idle("c_wb_fwd", 0, 4'b0100);
    drain();
    step("d_mul", 1, 1, 2, 2'b11, 7, 1, 0, 1, 0, 0, 4'b0000, 2'b00);
    step("d_add_hold1", 1, 7, 2, 2'b11, 8, 1, 0, 0, 0, 1, 4'b0000, 2'b00);
    step("d_add_hold2", 1, 7, 2, 2'b11, 8, 1, 0, 0, 0, 1, 4'b0000, 2'b00);
    step("d_add_go", 1, 7, 2, 2'b11, 8, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    idle("d_fwd_mem", 0, 4'b0010);
    drain();
    step("e_w1", 1, 1, 2, 2'b11, 0, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    step("e_w2", 1, 1, 2, 2'b11, 0, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    step("e_c1", 1, 0, 0, 2'b11, 9, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    step("e_c2_r0", 1, 0, 0, 2'b11, 10, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    step("e_lw_r0", 1, 1, 0, 2'b01, 0, 1, 1, 0, 0, 0, 4'b0000, 2'b00);
    step("e_c3_nostall", 1, 0, 0, 2'b11, 11, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    drain();
    step("f_lw", 1, 1, 0, 2'b01, 5, 1, 1, 0, 0, 0, 4'b0000, 2'b00);
    step("f_flush", 1, 5, 0, 2'b01, 6, 1, 0, 0, 1, 0, 4'b0000, 2'b00);
    step("f_x", 1, 5, 6, 2'b11, 10, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    idle("f_bubble_chk", 0, 4'b0001);
    drain();
    step("g_mul", 1, 1, 2, 2'b11, 7, 1, 0, 1, 0, 0, 4'b0000, 2'b00);
    idle("g_busy", 1);
    idle("g_rst_low", 1, 4'b0000, 1'b0);
    step("g_add_after_rst", 1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    step("g_sub", 1, 3, 4, 2'b11, 6, 1, 0, 0, 0, 0, 4'b0000, 2'b00);
    idle("g_fwd_mem", 0, 4'b0010);
    drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
